// File: rtl/riscv_pkg.sv
// Shared load/store encodings, MEM-stage state enum and byte-lane helpers for mem_stage.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Reserved encodings fall through to a word access.
    function automatic acc_size_t acc_size(input logic is_store, input logic [2:0] f3);
        acc_size_t sz;
        sz = SZ_W;
        if (is_store) begin
            if (f3 == F3_SB)      sz = SZ_B;
            else if (f3 == F3_SH) sz = SZ_H;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_B;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic [3:0] lane_be(input acc_size_t sz, input logic [1:0] lo2);
        case (sz)
            SZ_B:    return 4'b0001 << lo2;
            SZ_H:    return 4'b0011 << {lo2[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input acc_size_t sz, input logic [31:0] sd);
        case (sz)
            SZ_B:    return {4{sd[7:0]}};
            SZ_H:    return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic misaligned(input acc_size_t sz, input logic [1:0] lo2);
        return ((sz == SZ_H) && lo2[0]) || ((sz == SZ_W) && (lo2 != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int WIDTH = 32
);
    logic               dmem_req;
    logic               dmem_ready;
    logic               dmem_we;
    logic [WIDTH-1:0]   dmem_addr;
    logic [WIDTH/8-1:0] dmem_be;
    logic [WIDTH-1:0]   dmem_wdata;
    logic               dmem_rvalid;
    logic [WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a raw load word and sign/zero-extends it.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lo2_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = 8'(rdata_i >> {lo2_i, 3'b000});
    assign lane_h = 16'(rdata_i >> {lo2_i[1], 4'b0000});

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data_o = {24'd0, lane_b};
            F3_LH:   data_o = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data_o = {16'd0, lane_h};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX->WB memory-access stage with an IDLE/REQ/WAIT data-memory handshake.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and flagged on `misalign`.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [WIDTH-1:0]    store_data,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic [2:0]          funct3,
    input  logic [REG_ADDR-1:0] rd,
    input  logic                regWrite,
    input  logic                memToReg_in,
    mem_stage_if.master         dmem,
    output logic                wb_valid,
    output logic [WIDTH-1:0]    data_read,
    output logic [WIDTH-1:0]    alu_data,
    output logic                memToReg,
    output logic [REG_ADDR-1:0] rd_out,
    output logic                regWrite_out
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                misalign
`endif
);
    mem_state_t          state_q, state_d;
    logic [WIDTH-1:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic [WIDTH/8-1:0]  be_q, be_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lo2_q, lo2_d;
    logic [WIDTH-1:0]    alu_q, alu_d, data_q, data_d;
    logic [REG_ADDR-1:0] rd_q, rd_d;
    logic                mtr_q, mtr_d, regwr_q, regwr_d, wbv_q, wbv_d;
    logic [WIDTH-1:0]    ld_data;
    acc_size_t           sz_in;

    assign sz_in = acc_size(memWrite, funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_in, mis_q, mis_d;
    assign mis_in   = misaligned(sz_in, alu_result[1:0]);
    assign misalign = mis_q;
`endif

    load_align u_align (
        .rdata_i  (dmem.dmem_rdata),
        .lo2_i    (lo2_q),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lo2_d   = lo2_q;
        alu_d   = alu_q;
        data_d  = data_q;
        rd_d    = rd_q;
        mtr_d   = mtr_q;
        regwr_d = regwr_q;
        wbv_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_d   = alu_result;
                    rd_d    = rd;
                    regwr_d = regWrite;
                    mtr_d   = memToReg_in;
                    f3_d    = funct3;
                    lo2_d   = alu_result[1:0];
                    if (memRead || memWrite) begin
                        addr_d  = {alu_result[WIDTH-1:2], 2'b00};
                        be_d    = lane_be(sz_in, alu_result[1:0]);
                        wdata_d = store_lanes(sz_in, store_data);
                        we_d    = memWrite;
`ifdef MEM_MISALIGN_TRAP_EN
                        if (mis_in) begin
                            wbv_d   = 1'b1;
                            regwr_d = 1'b0;
                            mis_d   = 1'b1;
                        end else
`endif
                        state_d = REQ;
                    end else begin
                        wbv_d = 1'b1;
                    end
                end
            end
            // Request fields stay frozen until the memory accepts.
            REQ: begin
                if (dmem.dmem_ready) begin
                    if (we_q) begin
                        wbv_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem.dmem_rvalid) begin
                    data_d  = ld_data;
                    wbv_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lo2_q   <= '0;
            alu_q   <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            mtr_q   <= 1'b0;
            regwr_q <= 1'b0;
            wbv_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lo2_q   <= lo2_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            mtr_q   <= mtr_d;
            regwr_q <= regwr_d;
            wbv_q   <= wbv_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wbv_q;
    assign data_read       = data_q;
    assign alu_data        = alu_q;
    assign memToReg        = mtr_q;
    assign rd_out          = rd_q;
    assign regWrite_out    = wbv_q & regwr_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a behavioural model.
module tb_mem_stage;
    localparam int WIDTH    = 32;
    localparam int REG_ADDR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, in_valid, in_ready, memRead, memWrite, regWrite, memToReg_in;
    logic [WIDTH-1:0]    alu_result, store_data, data_read, alu_data;
    logic [2:0]          funct3;
    logic [REG_ADDR-1:0] rd, rd_out;
    logic                wb_valid, memToReg, regWrite_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misalign;
`endif

    mem_stage_if #(.WIDTH(WIDTH)) dmem_bus ();

    mem_stage #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .funct3       (funct3),
        .rd           (rd),
        .regWrite     (regWrite),
        .memToReg_in  (memToReg_in),
        .dmem         (dmem_bus),
        .wb_valid     (wb_valid),
        .data_read    (data_read),
        .alu_data     (alu_data),
        .memToReg     (memToReg),
        .rd_out       (rd_out),
        .regWrite_out (regWrite_out)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        regwr;
        logic        mtr;
        logic        is_load;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Behavioural model: access size in bytes, lane offset, byte enables, replicated store data, load extension.
    function automatic int acc_bytes(input bit is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_off(input int sz, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return (lo / sz) * sz;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
        int m;
        m = ((1 << sz) - 1) << lane_off(sz, a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sd);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        int          sz, off;
        logic [31:0] mask, v;
        sz = acc_bytes(1'b0, f3);
        if (sz == 4) return rdat;
        off  = lane_off(sz, a);
        mask = (32'd1 << (8*sz)) - 32'd1;
        v    = (rdat >> (8*off)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk_req(input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd, input bit st);
        chk("req_held",    32'(dmem_bus.dmem_req), 1);
        chk("req_addr",    dmem_bus.dmem_addr, eaddr);
        chk("req_be",      32'(dmem_bus.dmem_be), 32'(ebe));
        chk("req_we",      32'(dmem_bus.dmem_we), 32'(st));
        if (st) chk("req_wdata", dmem_bus.dmem_wdata, ewd);
        chk("in_ready_busy", 32'(in_ready), 0);
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input int rdy_dly, input int rv_dly,
                         input logic [4:0] rdx, input logic rw, input logic mt);
        exp_t        e;
        int          sz;
        bit          mis;
        logic [31:0] eaddr, ewd;
        logic [3:0]  ebe;
        sz    = acc_bytes(kind == 2, f3);
        mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (kind != 0 && sz > 1 && (int'(a[1:0]) % sz) != 0) mis = 1'b1;
`endif
        eaddr = a & ~32'd3;
        ebe   = model_be(sz, a);
        ewd   = model_wdata(sz, sd);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid    = 1'b1;
        alu_result  = a;
        store_data  = sd;
        memRead     = (kind == 1);
        memWrite    = (kind == 2);
        funct3      = f3;
        rd          = rdx;
        regWrite    = rw;
        memToReg_in = mt;
        e.alu     = a;
        e.rd      = rdx;
        e.regwr   = rw && !mis;
        e.mtr     = mt;
        e.is_load = (kind == 1) && !mis;
        e.data    = (kind == 1) ? model_load(f3, a, rdat) : 32'd0;
        e.mis     = mis;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        alu_result = $urandom;
        store_data = $urandom;
        funct3     = 3'($urandom);
        rd         = 5'($urandom);
        if (kind != 0 && !mis) begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk_req(eaddr, ebe, ewd, kind == 2);
                dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_bus.dmem_rdata  = $urandom;
                @(negedge clk);
            end
            chk_req(eaddr, ebe, ewd, kind == 2);
            dmem_bus.dmem_rvalid = 1'b0;
            dmem_bus.dmem_ready  = 1'b1;
            @(negedge clk);
            dmem_bus.dmem_ready = 1'b0;
            if (kind == 1) begin
                for (int i = 0; i < rv_dly; i++) begin
                    chk("req_dropped",    32'(dmem_bus.dmem_req), 0);
                    chk("in_ready_wait",  32'(in_ready), 0);
                    chk("wb_early",       32'(wb_valid), 0);
                    @(negedge clk);
                end
                dmem_bus.dmem_rvalid = 1'b1;
                dmem_bus.dmem_rdata  = rdat;
                @(negedge clk);
                dmem_bus.dmem_rvalid = 1'b0;
                dmem_bus.dmem_rdata  = $urandom;
            end
        end else begin
            chk("no_req", 32'(dmem_bus.dmem_req), 0);
        end
        chk("wb_latency", 32'(wb_valid), 1);
    endtask

    // Compare process: every WB pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wb_valid) begin
                chk("wb_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wb_alu_data", alu_data, mon_e.alu);
                    chk("wb_rd_out",   32'(rd_out), 32'(mon_e.rd));
                    chk("wb_memToReg", 32'(memToReg), 32'(mon_e.mtr));
                    chk("wb_regWrite", 32'(regWrite_out), 32'(mon_e.regwr));
                    if (mon_e.is_load) chk("wb_data_read", data_read, mon_e.data);
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("wb_misalign", 32'(misalign), 32'(mon_e.mis));
`endif
                end
            end else begin
                chk("regwr_gated", 32'(regWrite_out), 0);
`ifdef MEM_MISALIGN_TRAP_EN
                chk("misalign_idle", 32'(misalign), 0);
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; memRead = 1'b0; memWrite = 1'b0;
        funct3 = '0; rd = '0; regWrite = 1'b0; memToReg_in = 1'b0;
        dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_req",       32'(dmem_bus.dmem_req), 0);
        chk("rst_we",        32'(dmem_bus.dmem_we), 0);
        chk("rst_addr",      dmem_bus.dmem_addr, 0);
        chk("rst_be",        32'(dmem_bus.dmem_be), 0);
        chk("rst_wdata",     dmem_bus.dmem_wdata, 0);
        chk("rst_wb_valid",  32'(wb_valid), 0);
        chk("rst_regwr",     32'(regWrite_out), 0);
        chk("rst_data_read", data_read, 0);
        chk("rst_alu_data",  alu_data, 0);
        chk("rst_memToReg",  32'(memToReg), 0);
        chk("rst_rd_out",    32'(rd_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 0, 0, 5'd3, 1'b1, 1'b0);
        chk("add_alu_data", alu_data, 32'h0000_1234);
        chk("add_memToReg", 32'(memToReg), 0);
        chk("add_regwr",    32'(regWrite_out), 1);

        do_op(1, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 0, 0, 5'd5, 1'b1, 1'b1);
        chk("lb_data", data_read, 32'hFFFF_FF80);
        do_op(1, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 0, 0, 5'd6, 1'b1, 1'b1);
        chk("lbu_data", data_read, 32'h0000_0080);
        chk("lbu_be",   32'(dmem_bus.dmem_be), 32'h8);

        do_op(2, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0, 0, 5'd0, 1'b0, 1'b0);
        chk("sh_be",    32'(dmem_bus.dmem_be), 32'hC);
        chk("sh_wdata", dmem_bus.dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we",    32'(dmem_bus.dmem_we), 1);
        chk("sh_regwr", 32'(regWrite_out), 0);

        do_op(1, 3'b010, 32'h0000_4000, 32'd0, 32'hDEAD_BEEF, 4, 2, 5'd7, 1'b1, 1'b1);
        chk("stall_lw_data", data_read, 32'hDEAD_BEEF);

        // Reset while waiting for load data: the op is dropped and a late rvalid must not revive it.
        in_valid = 1'b1; alu_result = 32'h0000_0040; memRead = 1'b1; funct3 = 3'b010; rd = 5'd9; regWrite = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; memRead = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwait_req",      32'(dmem_bus.dmem_req), 0);
        chk("rstwait_wb",       32'(wb_valid), 0);
        chk("rstwait_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", 32'(wb_valid), 0);
        @(negedge clk);
        chk("late_rvalid_wb2", 32'(wb_valid), 0);
        chk("late_rvalid_data", data_read, 0);

        do_op(1, 3'b010, 32'h0000_3001, 32'd0, 32'h5555_AAAA, 1, 1, 5'd8, 1'b1, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("trap_misalign", 32'(misalign), 1);
        chk("trap_regwr",    32'(regWrite_out), 0);
`else
        chk("trunc_addr", dmem_bus.dmem_addr, 32'h0000_3000);
        chk("trunc_be",   32'(dmem_bus.dmem_be), 32'hF);
`endif

        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [2:0]  f3;
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom);
            do_op(kind, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                dmem_bus.dmem_rvalid = 1'b1;
                @(negedge clk);
                dmem_bus.dmem_rvalid = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
